// File: rtl/idft_synth_if.sv
// rtl/idft_synth_if.sv - sample stream interface from the synthesiser to the DAC/PWM path
//   sample_out   : signed time-domain sample, data_width*2 bits
//   sample_valid : sample_out holds a sample
//   sample_ready : downstream accepts sample_out this cycle
//   sample_last  : sample_out is the last sample of a period (n = N-1)
interface idft_synth_if #(
    parameter int data_width = 8
);
    logic signed [2*data_width-1:0] sample_out;
    logic                           sample_valid;
    logic                           sample_ready;
    logic                           sample_last;

    modport master (
        output sample_out,
        output sample_valid,
        output sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        input  sample_last,
        output sample_ready
    );
endinterface

// File: rtl/idft_synth.sv
// rtl/idft_synth.sv - inverse-DFT tone synthesiser, one real sample per frame from N complex bins
//   clk, reset_n            : clock (rising edge), asynchronous active-low reset
//   enable                  : permits starting the next sample computation
//   bin_we/addr/real/imag   : write port of the staging bin bank
//   commit, commit_pending  : queue a staging->active copy, applied at the next n=0 start
//   smp (idft_synth_if)     : sample_out/sample_valid/sample_ready/sample_last stream
//   Optional macro IDFT_SATURATE_EN: saturate the scaled sample instead of wrapping it.
module idft_synth #(
    parameter int data_width = 8,
    parameter int freq_bins  = 8,
    parameter int OUT_SHIFT  = 3
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                bin_we,
    input  logic [$clog2(freq_bins)-1:0]        bin_addr,
    input  logic signed [2*data_width-1:0]      bin_real,
    input  logic signed [2*data_width-1:0]      bin_imag,
    input  logic                                commit,
    output logic                                commit_pending,
    idft_synth_if.master                        smp
);
    localparam int BW    = 2 * data_width;
    localparam int LOGN  = $clog2(freq_bins);
    localparam int AW    = BW + 16 + LOGN + 1;
    localparam int SHIFT = 7 + OUT_SHIFT;

    typedef logic [freq_bins-1:0][15:0] tab_t;

    localparam logic signed [63:0] TWO_PI_Q28 = 64'sd1686629713;
    localparam logic signed [63:0] ONE_Q28    = 64'sd268435456;
    localparam logic signed [63:0] HALF_Q28   = 64'sd134217728;

    // Twiddle table round(128*cos/sin(2*pi*m/N)), the same contents as the
    // analyser's twiddle_real.list / twiddle_imag.list. Built at elaboration:
    // the angle is folded into the first quadrant so a short Taylor series in
    // Q28 stays well inside 64 bits and far below the 1/128 rounding step.
    function automatic tab_t build_tab(input bit want_sin);
        tab_t                t;
        logic signed [63:0]  x, x2, term, c, s, ci, si, cv, sv;
        int                  q, r;
        t = '0;
        for (int m = 0; m < freq_bins; m++) begin
            q  = m / (freq_bins / 4);
            r  = m % (freq_bins / 4);
            x  = (TWO_PI_Q28 * 64'(r)) / 64'(freq_bins);
            x2 = (x * x) >>> 28;
            c    = 64'sd0;
            term = ONE_Q28;
            for (int i = 0; i < 10; i++) begin
                c    = c + term;
                term = -(((term * x2) >>> 28) / 64'((2*i+1) * (2*i+2)));
            end
            s    = 64'sd0;
            term = x;
            for (int j = 0; j < 10; j++) begin
                s    = s + term;
                term = -(((term * x2) >>> 28) / 64'((2*j+2) * (2*j+3)));
            end
            ci = (c * 64'sd128 + HALF_Q28) >>> 28;
            si = (s * 64'sd128 + HALF_Q28) >>> 28;
            case (q)
                0:       begin cv = ci;  sv = si;  end
                1:       begin cv = -si; sv = ci;  end
                2:       begin cv = -ci; sv = -si; end
                default: begin cv = si;  sv = -ci; end
            endcase
            t[m] = want_sin ? sv[15:0] : cv[15:0];
        end
        return t;
    endfunction

    localparam tab_t COS_TAB = build_tab(1'b0);
    localparam tab_t SIN_TAB = build_tab(1'b1);

`ifdef IDFT_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BW+1){1'b1}}, {(BW-1){1'b0}}};

    function automatic logic signed [BW-1:0] scale_out(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] yf;
        yf = a >>> SHIFT;
        if (yf > SAT_MAX)      return BW'(SAT_MAX);
        else if (yf < SAT_MIN) return BW'(SAT_MIN);
        else                   return BW'(yf);
    endfunction
`else
    function automatic logic signed [BW-1:0] scale_out(input logic signed [AW-1:0] a);
        return BW'(a >>> SHIFT);
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [LOGN-1:0]        n_q, n_d;
    logic [LOGN-1:0]        k_q, k_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [BW-1:0]   out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   pend_q, pend_d;
    logic signed [BW-1:0]   stg_re_q [freq_bins];
    logic signed [BW-1:0]   stg_re_d [freq_bins];
    logic signed [BW-1:0]   stg_im_q [freq_bins];
    logic signed [BW-1:0]   stg_im_d [freq_bins];
    logic signed [BW-1:0]   act_re_q [freq_bins];
    logic signed [BW-1:0]   act_re_d [freq_bins];
    logic signed [BW-1:0]   act_im_q [freq_bins];
    logic signed [BW-1:0]   act_im_d [freq_bins];

    logic [LOGN-1:0]        m;
    logic signed [15:0]     cos_tw;
    logic signed [15:0]     sin_tw;
    logic signed [AW-1:0]   term;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        acc_d    = acc_q;
        out_d    = out_q;
        valid_d  = valid_q;
        last_d   = last_q;
        pend_d   = pend_q;
        stg_re_d = stg_re_q;
        stg_im_d = stg_im_q;
        act_re_d = act_re_q;
        act_im_d = act_im_q;

        // Twiddle index (k*n) mod N: the product is simply truncated to LOGN bits.
        m      = k_q * n_q;
        cos_tw = $signed(COS_TAB[m]);
        sin_tw = $signed(SIN_TAB[m]);
        term   = AW'(act_re_q[k_q]) * AW'(cos_tw) - AW'(act_im_q[k_q]) * AW'(sin_tw);

        if (bin_we) begin
            stg_re_d[bin_addr] = bin_real;
            stg_im_d[bin_addr] = bin_imag;
        end
        if (commit) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACCUM;
                    k_d     = '0;
                    acc_d   = '0;
                    // Copy from the registered staging bank so a write in this
                    // same cycle lands in staging only.
                    if (pend_q && (n_q == '0)) begin
                        act_re_d = stg_re_q;
                        act_im_d = stg_im_q;
                        pend_d   = 1'b0;
                    end
                end
            end
            ACCUM: begin
                acc_d = acc_q + term;
                k_d   = k_q + LOGN'(1);
                if (k_q == LOGN'(freq_bins - 1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                out_d   = scale_out(acc_q);
                valid_d = 1'b1;
                last_d  = (n_q == LOGN'(freq_bins - 1));
                state_d = HOLD;
            end
            HOLD: begin
                if (valid_q && smp.sample_ready) begin
                    valid_d = 1'b0;
                    n_d     = n_q + LOGN'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            pend_q   <= 1'b0;
            stg_re_q <= '{default: '0};
            stg_im_q <= '{default: '0};
            act_re_q <= '{default: '0};
            act_im_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            stg_re_q <= stg_re_d;
            stg_im_q <= stg_im_d;
            act_re_q <= act_re_d;
            act_im_q <= act_im_d;
        end
    end

    assign smp.sample_out   = out_q;
    assign smp.sample_valid = valid_q;
    assign smp.sample_last  = last_q;
    assign commit_pending   = pend_q;
endmodule
